// File: rtl/ttl_74259_sync_pkg.sv
// ttl_pkg: shared latch-mode encoding and mode selection for addressable-latch style parts.
// Mode selection follows the 74x259 truth table, with clear/write qualified externally.
package ttl_pkg;

    typedef enum logic [1:0] {
        LM_MEMORY,
        LM_LATCH,
        LM_DEMUX,
        LM_CLEAR
    } latch_mode_t;

    function automatic latch_mode_t mode_of(input logic clr_n, input logic wr);
        return clr_n ? (wr ? LM_LATCH : LM_MEMORY) : (wr ? LM_DEMUX : LM_CLEAR);
    endfunction

endpackage

// File: rtl/ttl_74259_sync_dec.sv
// addr_onehot_dec: combinational address to one-hot decoder with range check.
// Addresses at or above WIDTH_OUT decode to all zeros.
module addr_onehot_dec #(
    parameter int WIDTH_OUT = 8,
    parameter int WIDTH_IN  = $clog2(WIDTH_OUT)
) (
    input  logic [WIDTH_IN-1:0]  i_a,
    output logic [WIDTH_OUT-1:0] o_onehot
);

    logic w_hit;

    assign w_hit = 32'(i_a) < WIDTH_OUT;

    for (genvar i = 0; i < WIDTH_OUT; i++) begin : g_bit
        assign o_onehot[i] = w_hit && (32'(i_a) == i);
    end

endmodule

// File: rtl/ttl_74259_sync.sv
// ttl_74259_sync: clocked 74LS259 addressable latch, WIDTH_OUT bits wide,
// with optional strobe-edge writes and a per-bit change pulse aligned with Q.
module ttl_74259_sync
    import ttl_pkg::*;
#(
    parameter int                   WIDTH_OUT = 8,
    parameter int                   WIDTH_IN  = $clog2(WIDTH_OUT),
    parameter bit                   EDGE_MODE = 1'b0,
    parameter logic [WIDTH_OUT-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic                 CLR_n,
    input  logic                 G_n,
    input  logic                 D,
    input  logic [WIDTH_IN-1:0]  A,
    output logic [WIDTH_OUT-1:0] Q,
    output logic [WIDTH_OUT-1:0] Changed
);

    logic                 r_g_n_q;
    logic                 w_wr;
    latch_mode_t          w_mode;
    logic [WIDTH_OUT-1:0] w_onehot;
    logic [WIDTH_OUT-1:0] w_data;
    logic [WIDTH_OUT-1:0] w_q_next;

    addr_onehot_dec #(
        .WIDTH_OUT(WIDTH_OUT),
        .WIDTH_IN (WIDTH_IN)
    ) u_dec (
        .i_a     (A),
        .o_onehot(w_onehot)
    );

    // In edge mode r_g_n_q resets high, so a strobe already low at release counts as an edge.
    assign w_wr     = ce & ~G_n & (EDGE_MODE ? r_g_n_q : 1'b1);
    assign w_mode   = mode_of(CLR_n, w_wr);
    assign w_data   = w_onehot & {WIDTH_OUT{D}};
    assign w_q_next = (w_mode == LM_LATCH) ? (Q & ~w_onehot) | w_data :
                      (w_mode == LM_DEMUX) ? w_data :
                      (w_mode == LM_CLEAR) ? '0 : Q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q       <= RESET_VAL;
            Changed <= '0;
            r_g_n_q <= 1'b1;
        end else if (ce) begin
            Q       <= w_q_next;
            Changed <= w_q_next ^ Q;
            r_g_n_q <= G_n;
        end
    end

endmodule

// File: tb/tb_ttl_74259_sync.sv
// tb_ttl_74259_sync: directed vectors for level mode, plus hand sequences for
// edge mode, async reset and a non-power-of-two width.
module tb_ttl_74259_sync;

    logic       clk;
    logic       reset_n;
    logic       ce;
    logic       clr_n;
    logic       g_n;
    logic       d;
    logic [2:0] a;
    logic [7:0] q0, ch0, q1, ch1;
    logic [5:0] q2, ch2;
    int         checks;
    int         errors;
    int         pulses;

    typedef struct {
        logic       ce;
        logic       clr_n;
        logic       g_n;
        logic       d;
        logic [2:0] a;
        logic [7:0] q;
        logic [7:0] ch;
    } vec_t;

    vec_t vt[26];

    ttl_74259_sync #(.WIDTH_OUT(8), .EDGE_MODE(1'b0), .RESET_VAL(8'hA5)) u0 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .CLR_n(clr_n), .G_n(g_n),
        .D(d), .A(a), .Q(q0), .Changed(ch0)
    );

    ttl_74259_sync #(.WIDTH_OUT(8), .EDGE_MODE(1'b1), .RESET_VAL(8'h00)) u1 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .CLR_n(clr_n), .G_n(g_n),
        .D(d), .A(a), .Q(q1), .Changed(ch1)
    );

    ttl_74259_sync #(.WIDTH_OUT(6), .EDGE_MODE(1'b0), .RESET_VAL(6'h00)) u2 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .CLR_n(clr_n), .G_n(g_n),
        .D(d), .A(a), .Q(q2), .Changed(ch2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic cl, input logic g, input logic dd, input logic [2:0] aa);
        ce    = c;
        clr_n = cl;
        g_n   = g;
        d     = dd;
        a     = aa;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        //               ce clr g  d  a     Q      Changed
        vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'hA5, 8'h00};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'hA5};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08, 8'h08};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08, 8'h00};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 8'h88, 8'h80};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 8'h80, 8'h08};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 8'h81, 8'h01};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h81, 8'h01};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h81, 8'h01};
        vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h81, 8'h00};
        vt[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'h83, 8'h02};
        vt[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 8'h87, 8'h04};
        vt[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 8'h8F, 8'h08};
        vt[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 8'h9F, 8'h10};
        vt[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 8'hBF, 8'h20};
        vt[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 8'hFF, 8'h40};
        vt[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 8'hDF};
        vt[18] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'h00, 8'h20};
        vt[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h00};
        vt[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h00, 8'h00};
        vt[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h00, 8'h00};
        vt[22] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'h02, 8'h02};
        vt[23] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02, 8'h02};
        vt[24] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02, 8'h02};
        vt[25] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02, 8'h00};

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset_q", q0, 8'hA5);
        chk("reset_changed", ch0, 8'h00);

        foreach (vt[i]) begin
            drive(vt[i].ce, vt[i].clr_n, vt[i].g_n, vt[i].d, vt[i].a);
            tick();
            chk($sformatf("vec%0d_q", i), q0, vt[i].q);
            chk($sformatf("vec%0d_changed", i), ch0, vt[i].ch);
        end

        // Reset arriving mid-cycle right after a write must restore Q without a clock edge.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd7);
        @(posedge clk);
        #1;
        chk("pre_async_q", q0, 8'h82);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_q", q0, 8'hA5);
        chk("async_reset_changed", ch0, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);

        // Edge mode: one write per strobe, later A/D changes ignored.
        tick();
        chk("edge_idle_q", q1, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
        tick();
        chk("edge_write_q", q1, 8'h04);
        pulses = (ch1 != 8'h00) ? 1 : 0;
        a = 3'd6;
        for (int k = 0; k < 4; k++) begin
            tick();
            pulses += (ch1 != 8'h00) ? 1 : 0;
        end
        chk("edge_hold_q", q1, 8'h04);
        chk("edge_pulse_count", 8'(pulses), 8'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
        tick();
        chk("edge_demux_q", q1, 8'h20);
        chk("edge_demux_changed", ch1, 8'h24);
        clr_n = 1'b1;
        d     = 1'b0;
        tick();
        chk("edge_consumed_q", q1, 8'h20);
        chk("edge_consumed_changed", ch1, 8'h00);
        clr_n = 1'b0;
        tick();
        chk("edge_level_clear_q", q1, 8'h00);
        chk("edge_level_clear_changed", ch1, 8'h20);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
        tick();
        chk("edge_ce0_q", q1, 8'h00);
        ce = 1'b1;
        tick();
        chk("edge_between_ce_q", q1, 8'h02);
        chk("edge_between_ce_changed", ch1, 8'h02);
        tick();
        chk("edge_between_ce_hold", q1, 8'h02);

        // Six-bit instance: out-of-range address never writes, demux with it clears.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd1);
        tick();
        chk("w6_write_q", {2'b00, q2}, 8'h02);
        a = 3'd7;
        tick();
        chk("w6_oor_q", {2'b00, q2}, 8'h02);
        chk("w6_oor_changed", {2'b00, ch2}, 8'h00);
        clr_n = 1'b0;
        tick();
        chk("w6_oor_demux_q", {2'b00, q2}, 8'h00);
        chk("w6_oor_demux_changed", {2'b00, ch2}, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
